// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - receive-side controller: graceful receiver enable, byte FIFO, overrun and idle events
//
// Purpose: holds the UART receiver in reset while disabled and releases or
// re-asserts that reset without cutting a frame in half. Completed bytes are
// captured on rxDone into a small FIFO drained through a valid/ready handshake.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rxEnable            level request to run the receiver
//   flush               pulse, empties the FIFO
//   rxLine              serial line as seen by the receiver
//   rxDone, rxByte      receiver done pulse and received byte
//   rxRst               registered reset to the receiver (1 while OFF)
//   outData, outValid   FIFO head byte (0 when empty) and non-empty flag
//   outReady            consumer accept
//   count               FIFO occupancy, 0..FIFO_DEPTH
//   overrun             sticky drop flag, cleared by clearOverrun
//   idleFlag            one-cycle pulse when the line goes idle after data
module uart_rx_ctrl #(
  parameter int FIFO_DEPTH  = 4,
  parameter int IDLE_CYCLES = 20,
  parameter int FRAME_IDLE  = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rxEnable,
  input  logic                        flush,
  input  logic                        rxLine,
  input  logic                        rxDone,
  input  logic [7:0]                  rxByte,
  output logic                        rxRst,
  output logic [7:0]                  outData,
  output logic                        outValid,
  input  logic                        outReady,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        overrun,
  input  logic                        clearOverrun,
  output logic                        idleFlag
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = $clog2(IDLE_CYCLES + 1);
  localparam int FW = $clog2(FRAME_IDLE + 1);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);
  localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_CYCLES);
  localparam logic [FW-1:0] FRAME_MAX = FW'(FRAME_IDLE);

  typedef enum logic [1:0] {S_OFF, S_RUN, S_STOP} state_t;

  state_t        state_q;
  logic          rx_rst_q;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          overrun_q;
  logic [IW-1:0] idle_q;
  logic          armed_q;
  logic          idle_flag_q;
  logic [FW-1:0] fidle_q, fidle_d;

  logic push_req, empty, full, pop, push, drop, stop_exit;

  assign push_req = rxDone & (state_q != S_OFF);
  assign empty    = (count_q == '0);
  assign full     = (count_q == FULL_CNT);
  assign pop      = ~empty & outReady & ~flush;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push     = push_req & ~flush & (~full | pop);
  assign drop     = push_req & ~flush & full & ~pop;

  // Frame-idle run length; held at 0 outside STOPPING so entry starts clean.
  always_comb begin
    fidle_d = '0;
    if (state_q == S_STOP && rxLine) begin
      fidle_d = (fidle_q == FRAME_MAX) ? fidle_q : fidle_q + 1'b1;
    end
  end

  // Exit fires on the edge where the run length reaches FRAME_IDLE.
  assign stop_exit = rxDone | (fidle_d == FRAME_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_OFF;
      rx_rst_q <= 1'b1;
      fidle_q  <= '0;
    end else begin
      fidle_q <= fidle_d;
      case (state_q)
        S_OFF: begin
          if (rxEnable) begin
            state_q  <= S_RUN;
            rx_rst_q <= 1'b0;
          end
        end
        S_RUN: begin
          if (!rxEnable) state_q <= S_STOP;
        end
        S_STOP: begin
          if (rxEnable) begin
            state_q <= S_RUN;
          end else if (stop_exit) begin
            state_q  <= S_OFF;
            rx_rst_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= S_OFF;
          rx_rst_q <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rxByte;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)               overrun_q <= 1'b0;
    else if (drop)         overrun_q <= 1'b1;
    else if (clearOverrun) overrun_q <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_q      <= '0;
      armed_q     <= 1'b0;
      idle_flag_q <= 1'b0;
    end else begin
      idle_flag_q <= 1'b0;
      if (state_q == S_RUN) begin
        if (push_req) begin
          idle_q  <= '0;
          armed_q <= 1'b1;
        end else begin
          if (armed_q && idle_q == IDLE_MAX) begin
            idle_flag_q <= 1'b1;
            armed_q     <= 1'b0;
          end
          if (!rxLine)                idle_q <= '0;
          else if (idle_q != IDLE_MAX) idle_q <= idle_q + 1'b1;
        end
      end else begin
        idle_q  <= '0;
        armed_q <= 1'b0;
      end
    end
  end

  assign rxRst    = rx_rst_q;
  assign outValid = ~empty;
  assign outData  = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign count    = count_q;
  assign overrun  = overrun_q;
  assign idleFlag = idle_flag_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - scoreboard testbench for uart_rx_ctrl
module tb_uart_rx_ctrl;

  localparam int DEPTH = 4;
  localparam int IDLE  = 20;
  localparam int FRAME = 10;

  logic       clk = 1'b0;
  logic       rst, rxEnable, flush, rxLine, rxDone, outReady, clearOverrun;
  logic [7:0] rxByte;
  logic       rxRst, outValid, overrun, idleFlag;
  logic [7:0] outData;
  logic [$clog2(DEPTH):0] count;

  always #5 clk = ~clk;

  uart_rx_ctrl #(.FIFO_DEPTH(DEPTH), .IDLE_CYCLES(IDLE), .FRAME_IDLE(FRAME)) dut (
    .clk(clk), .rst(rst), .rxEnable(rxEnable), .flush(flush), .rxLine(rxLine),
    .rxDone(rxDone), .rxByte(rxByte), .rxRst(rxRst), .outData(outData),
    .outValid(outValid), .outReady(outReady), .count(count), .overrun(overrun),
    .clearOverrun(clearOverrun), .idleFlag(idleFlag)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the byte queue doubles as the scoreboard of expected output.
  byte unsigned sb[$];
  int  m_state;   // 0 off, 1 run, 2 stopping
  bit  m_rxrst, m_ovr, m_flag, m_armed;
  int  m_idle, m_fidle;
  bit  mon_en = 1'b0;
  int  prev;
  bit  preq, dropped;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      sb.delete();
      m_state = 0; m_rxrst = 1; m_ovr = 0; m_flag = 0;
      m_armed = 0; m_idle = 0; m_fidle = 0;
      mon_en  = 1;
    end else begin
      prev    = m_state;
      preq    = rxDone && (prev != 0);
      dropped = 0;
      // The monitor has already removed this cycle's pop from sb.
      if (preq && !flush) begin
        if (sb.size() < DEPTH) sb.push_back(rxByte);
        else dropped = 1;
      end
      if (flush) sb.delete();
      if (dropped) m_ovr = 1;
      else if (clearOverrun) m_ovr = 0;

      m_flag = 0;
      if (prev == 1) begin
        if (preq) begin
          m_idle = 0; m_armed = 1;
        end else begin
          if (m_armed && m_idle == IDLE) begin m_flag = 1; m_armed = 0; end
          m_idle = rxLine ? ((m_idle < IDLE) ? m_idle + 1 : IDLE) : 0;
        end
      end else begin
        m_idle = 0; m_armed = 0;
      end

      if (prev == 2) m_fidle = rxLine ? ((m_fidle < FRAME) ? m_fidle + 1 : FRAME) : 0;
      else m_fidle = 0;

      case (prev)
        0: if (rxEnable) m_state = 1;
        1: if (!rxEnable) m_state = 2;
        default: begin
          if (rxEnable) m_state = 1;
          else if (rxDone || m_fidle == FRAME) m_state = 0;
        end
      endcase
      m_rxrst = (m_state == 0);
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("rxRst", rxRst, m_rxrst);
      chk("outValid", outValid, sb.size() != 0);
      chk("count", count, sb.size());
      chk("outData", outData, (sb.size() != 0) ? sb[0] : 8'h00);
      chk("overrun", overrun, m_ovr);
      chk("idleFlag", idleFlag, m_flag);
      if (sb.size() != 0 && outReady && !flush && !rst) begin
        chk("pop_data", outData, sb[0]);
        void'(sb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    rxDone = 1'b1; rxByte = b;
    tick();
    rxDone = 1'b0;
  endtask

  int pulses, when_idx, n;
  bit hold;

  initial begin
    rst = 1; rxEnable = 0; flush = 0; rxLine = 1; rxDone = 0;
    rxByte = 0; outReady = 0; clearOverrun = 0;
    tick(); tick();
    rst = 0;
    @(negedge clk);
    chk("plan_reset_rxRst", rxRst, 1);
    chk("plan_reset_count", count, 0);
    rxEnable = 1;
    tick();
    chk("plan_enable_rxRst", rxRst, 0);

    push_byte(8'hAA); push_byte(8'h55); push_byte(8'h0F); push_byte(8'hF0);
    @(negedge clk);
    chk("plan_full_count", count, 4);
    chk("plan_full_head", outData, 8'hAA);
    push_byte(8'h11);
    @(negedge clk);
    chk("plan_drop_count", count, 4);
    chk("plan_drop_overrun", overrun, 1);
    clearOverrun = 1; tick(); clearOverrun = 0;
    @(negedge clk);
    chk("plan_clear_overrun", overrun, 0);

    rxDone = 1; rxByte = 8'h77; outReady = 1;
    tick();
    rxDone = 0; outReady = 0;
    @(negedge clk);
    chk("plan_pushpop_count", count, 4);
    chk("plan_pushpop_overrun", overrun, 0);
    outReady = 1;
    repeat (6) tick();
    chk("plan_drained", count, 0);

    rxLine = 1;
    push_byte(8'h3C);
    pulses = 0; when_idx = 0;
    for (int i = 1; i <= 62; i++) begin
      @(negedge clk);
      if (idleFlag) begin pulses++; when_idx = i; end
    end
    chk("plan_idle_pulses", pulses, 1);
    chk("plan_idle_when", when_idx, IDLE + 2);

    rxLine = 0; rxEnable = 0;
    repeat (3) tick();
    push_byte(8'h96);
    chk("plan_stop_rxRst", rxRst, 1);
    rxLine = 1;
    tick();

    rxEnable = 1; tick();
    rxEnable = 0; n = 0;
    for (int i = 0; i < 30; i++) begin
      tick(); n++;
      if (rxRst) break;
    end
    chk("plan_frame_idle_edges", n, FRAME + 1);

    rxEnable = 1; outReady = 0; tick();
    push_byte(8'h01); push_byte(8'h02); push_byte(8'h03);
    flush = 1; rxDone = 1; rxByte = 8'hEE;
    tick();
    flush = 0; rxDone = 0;
    @(negedge clk);
    chk("plan_flush_count", count, 0);
    chk("plan_flush_valid", outValid, 0);
    chk("plan_flush_data", outData, 0);

    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 64 == 0) hold = ($urandom_range(0, 1) == 1);
      rxLine       = hold ? 1'b1 : ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) rxEnable = ~rxEnable;
      rxDone       = hold ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 4) == 0);
      rxByte       = 8'($urandom);
      outReady     = ($urandom_range(0, 2) == 0);
      flush        = ($urandom_range(0, 99) == 0);
      clearOverrun = ($urandom_range(0, 29) == 0);
      rst          = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 0; rxDone = 0; flush = 0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Receive-side controller for the UART receiver. It drives the receiver's reset to enable and disable it cleanly, without cutting a frame in half. It captures each completed byte, on the receiver's done pulse, into a small FIFO and presents the bytes to the consumer with a valid/ready handshake. It also reports overrun and line-idle events.

Parameters:
FIFO_DEPTH, 4, number of byte entries; must be a power of 2 and at least 2
IDLE_CYCLES, 20, consecutive high-line cycles after the last captured byte before idleFlag pulses; must be at least 2
FRAME_IDLE, 10, consecutive high-line cycles that prove no frame is in flight during shutdown

Ports:
clk  in  1  system clock; all logic is on the rising edge
rst  in  1  synchronous, active-high reset
rxEnable  in  1  level; 1 means receive, 0 means shut the receiver down gracefully
flush  in  1  one-cycle pulse; empties the FIFO
rxLine  in  1  the serial line, the same signal that feeds the receiver's recieverInput
rxDone  in  1  the receiver's done output
rxByte  in  8  the receiver's byteRecieved output
rxRst  out  1  drives the receiver's rst
outData  out  8  FIFO head byte
outValid  out  1  FIFO is non-empty
outReady  in  1  consumer accepts outData
count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
overrun  out  1  sticky; a byte was dropped because the FIFO was full
clearOverrun  in  1  pulse; clears overrun
idleFlag  out  1  one-cycle pulse; the line went idle after data

Behaviour:
- Reset (rst=1 at a clock edge): state=OFF, rxRst=1, outValid=0, outData=0, count=0, overrun=0, idleFlag=0. All pointers and the idle and frame counters are 0. Reset overrides every other input.
- FSM states: OFF, RUN, STOPPING.
  - OFF: rxRst=1; rxDone is ignored. rxEnable=1 moves to RUN on the next edge.
  - RUN: rxRst=0. rxEnable=0 moves to STOPPING.
  - STOPPING: rxRst=0; captures continue. Exit to OFF on the edge where rxDone=1 (that byte is still captured), or when the frame-idle counter reaches FRAME_IDLE. rxEnable=1 while in STOPPING returns to RUN; that takes precedence over the exit conditions.
- rxRst is registered: it equals 1 exactly when the registered state is OFF.
- Frame-idle counter:
  - Counts consecutive rxLine=1 cycles while in STOPPING; saturates at FRAME_IDLE.
  - Clears to 0 on rxLine=0 and on entry to STOPPING.
- Push:
  - A push happens when rxDone=1 in RUN or STOPPING; rxByte is written at that edge.
  - From an empty FIFO, outValid=1 and outData=rxByte on the following cycle, so capture latency is 1 cycle.
- Pop: when outValid & outReady; the head advances at the edge.
- outData equals the head entry when count>0, and 0 when count==0.
- outValid = (count != 0). count updates at each edge.
- Simultaneous push and pop:
  - With the FIFO not full: count is unchanged and both pointers advance.
  - With the FIFO full: the push is accepted (the pop frees the slot) and overrun is not set.
- Push while full without a pop: the byte is dropped, the FIFO is unchanged, and overrun=1 from the next cycle.
- overrun:
  - Cleared by clearOverrun.
  - If clearOverrun and a new drop occur in the same cycle, the set wins.
- flush:
  - Sets count=0 and both pointers=0 at the edge; this is independent of state.
  - A push in the same cycle is discarded, with no overrun.
  - A pop in the same cycle has no additional effect.
  - overrun is not affected.
- Pointers wrap modulo FIFO_DEPTH; count ranges over 0..FIFO_DEPTH.
- Idle detect, in RUN only:
  - The idle counter clears on each push and on rxLine=0, and counts cycles with rxLine=1, saturating at IDLE_CYCLES.
  - An armed bit is set by each push and cleared when idleFlag fires.
  - idleFlag=1 for exactly one cycle, the cycle after the counter reaches IDLE_CYCLES while armed.
  - Leaving RUN clears the counter and the armed bit.
- FIFO contents persist through OFF, so the consumer may drain while the receiver is disabled.

Test Plan:
- Reset with rxEnable=0 -> rxRst=1, outValid=0, count=0, overrun=0, idleFlag=0. Raise rxEnable -> rxRst=0 after 1 edge.
- RUN, outReady=0, four rxDone pulses with rxByte=8'hAA, 8'h55, 8'h0F, 8'hF0 -> count=4, outValid=1, outData=8'hAA. A fifth pulse (8'h11) -> byte dropped, overrun=1, count=4. clearOverrun -> overrun=0.
- FIFO full, rxDone=1 and outReady=1 in the same cycle -> count stays 4, overrun=0. Draining yields 8'h55, 8'h0F, 8'hF0, then the new byte.
- RUN, rxLine held high, one push of 8'h3C -> idleFlag pulses once, IDLE_CYCLES+1 cycles after the push. Keep the line high 40 more cycles with no push -> no second pulse.
- Drop rxEnable mid-frame (rxLine low), then rxDone with 8'h96 three cycles later -> byte captured, state OFF, rxRst=1 on the next edge. Separately: rxEnable=0 with rxLine high -> rxRst=1 after FRAME_IDLE+1 edges.
- count=3 and flush asserted together with rxDone -> count=0, outValid=0, outData=0, overrun unchanged.
